// File: rtl/pa_sysmap_pkg.sv
// pa_sysmap_pkg
//   Shared constants and types for the system-map lookup controller:
//   region count, field widths, default attribute for a miss, the
//   lookup FSM state encoding and the requester identifier.
//   Optional feature macro used by the slice: SYSMAP_CFG_LOCK_EN.
package pa_sysmap_pkg;

    localparam int unsigned SYSMAP_REGION_NUM = 8;
    localparam int unsigned SYSMAP_ADDR_W     = 20;
    localparam int unsigned SYSMAP_ATTR_W     = 5;
    localparam int unsigned SYSMAP_IDX_W      = 3;

    localparam logic [SYSMAP_ATTR_W-1:0] SYSMAP_DFLT_ATTR = 5'b00011;
    localparam logic [SYSMAP_IDX_W-1:0]  SYSMAP_LAST_IDX  = 3'(SYSMAP_REGION_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } sysmap_state_e;

    typedef enum logic {
        SRC_IFU = 1'b0,
        SRC_LSU = 1'b1
    } sysmap_src_e;

endpackage

// File: rtl/pa_sysmap_cfg_regs.sv
// pa_sysmap_cfg_regs
//   Region register file: per region a 20-bit top and a 5-bit attribute.
//   One write port, one indexed (combinational) read port.
//   With SYSMAP_CFG_LOCK_EN defined each region also carries a sticky lock
//   bit; a write to a locked region is dropped and wr_err pulses for one
//   cycle. Without the macro wr_lock is ignored and wr_err is tied low.
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en             : write strobe (already qualified by the handshake)
//   wr_idx/top/attr   : write target and data
//   wr_lock           : set the region's lock bit with this write
//   wr_err            : one-cycle pulse after a write hit a locked region
//   rd_idx            : read index
//   rd_top/rd_attr    : read data for rd_idx
module pa_sysmap_cfg_regs
    import pa_sysmap_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [SYSMAP_IDX_W-1:0]  wr_idx,
    input  logic [SYSMAP_ADDR_W-1:0] wr_top,
    input  logic [SYSMAP_ATTR_W-1:0] wr_attr,
    input  logic                     wr_lock,
    output logic                     wr_err,
    input  logic [SYSMAP_IDX_W-1:0]  rd_idx,
    output logic [SYSMAP_ADDR_W-1:0] rd_top,
    output logic [SYSMAP_ATTR_W-1:0] rd_attr
);

    logic [SYSMAP_REGION_NUM-1:0][SYSMAP_ADDR_W-1:0] top_q;
    logic [SYSMAP_REGION_NUM-1:0][SYSMAP_ATTR_W-1:0] attr_q;

    assign rd_top  = top_q[rd_idx];
    assign rd_attr = attr_q[rd_idx];

`ifdef SYSMAP_CFG_LOCK_EN
    logic [SYSMAP_REGION_NUM-1:0] lock_q;
    logic                         wr_blocked;

    assign wr_blocked = wr_en && lock_q[wr_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q  <= '0;
            attr_q <= '0;
            lock_q <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_blocked;
            if (wr_en && !wr_blocked) begin
                top_q[wr_idx]  <= wr_top;
                attr_q[wr_idx] <= wr_attr;
                if (wr_lock) begin
                    lock_q[wr_idx] <= 1'b1;
                end
            end
        end
    end
`else
    logic cfg_lock_unused;

    assign cfg_lock_unused = wr_lock;
    assign wr_err          = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q  <= '0;
            attr_q <= '0;
        end else if (wr_en) begin
            top_q[wr_idx]  <= wr_top;
            attr_q[wr_idx] <= wr_attr;
        end
    end
`endif

endmodule

// File: rtl/pa_sysmap_lookup_ctrl.sv
// pa_sysmap_lookup_ctrl
//   Arbitrates IFU/LSU lookup requests (round-robin when both pending),
//   scans the 8 system-map regions one per cycle in ascending order and
//   returns the first region whose top is above the address, or a miss
//   with the default attribute. Configuration writes are accepted only
//   while idle with no request pending. Optional region locking is built
//   when SYSMAP_CFG_LOCK_EN is defined.
// Ports
//   forever_cpuclk, cpurst        : clock, asynchronous active-high reset
//   ifu_req/ifu_addr/ifu_gnt      : IFU lookup request, address[31:12], grant
//   lsu_req/lsu_addr/lsu_gnt      : LSU lookup request, address[31:12], grant
//   rsp_vld/rsp_rdy               : response handshake
//   rsp_id                        : 0 = IFU, 1 = LSU
//   rsp_hit/rsp_attr/rsp_region   : lookup result
//   cfg_wr_vld/cfg_wr_rdy         : config write handshake
//   cfg_wr_idx/top/attr/lock      : config write payload
//   cfg_wr_err                    : write rejected by a region lock
module pa_sysmap_lookup_ctrl
    import pa_sysmap_pkg::*;
(
    input  logic                     forever_cpuclk,
    input  logic                     cpurst,
    input  logic                     ifu_req,
    input  logic [SYSMAP_ADDR_W-1:0] ifu_addr,
    output logic                     ifu_gnt,
    input  logic                     lsu_req,
    input  logic [SYSMAP_ADDR_W-1:0] lsu_addr,
    output logic                     lsu_gnt,
    output logic                     rsp_vld,
    input  logic                     rsp_rdy,
    output logic                     rsp_id,
    output logic                     rsp_hit,
    output logic [SYSMAP_ATTR_W-1:0] rsp_attr,
    output logic [SYSMAP_IDX_W-1:0]  rsp_region,
    input  logic                     cfg_wr_vld,
    output logic                     cfg_wr_rdy,
    input  logic [SYSMAP_IDX_W-1:0]  cfg_wr_idx,
    input  logic [SYSMAP_ADDR_W-1:0] cfg_wr_top,
    input  logic [SYSMAP_ATTR_W-1:0] cfg_wr_attr,
    input  logic                     cfg_wr_lock,
    output logic                     cfg_wr_err
);

    sysmap_state_e             state_q, state_d;
    logic [SYSMAP_IDX_W-1:0]   idx_q, idx_d;
    logic                      last_lsu_q;
    logic [SYSMAP_ADDR_W-1:0]  addr_q;
    logic                      id_q;

    logic                      grant;
    logic                      sel_lsu;
    logic                      scan_done;
    logic                      scan_hit;
    logic                      cfg_wr_en;
    logic [SYSMAP_ADDR_W-1:0]  rd_top;
    logic [SYSMAP_ATTR_W-1:0]  rd_attr;

    pa_sysmap_cfg_regs u_cfg_regs (
        .clk     (forever_cpuclk),
        .rst     (cpurst),
        .wr_en   (cfg_wr_en),
        .wr_idx  (cfg_wr_idx),
        .wr_top  (cfg_wr_top),
        .wr_attr (cfg_wr_attr),
        .wr_lock (cfg_wr_lock),
        .wr_err  (cfg_wr_err),
        .rd_idx  (idx_q),
        .rd_top  (rd_top),
        .rd_attr (rd_attr)
    );

    // First match by index: a lower region with a larger top wins even if
    // the region table is not monotonic.
    assign scan_hit  = (addr_q < rd_top);
    assign cfg_wr_en = cfg_wr_vld && cfg_wr_rdy;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        grant      = 1'b0;
        sel_lsu    = 1'b0;
        scan_done  = 1'b0;
        rsp_vld    = 1'b0;
        cfg_wr_rdy = 1'b0;
        ifu_gnt    = 1'b0;
        lsu_gnt    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cfg_wr_rdy = !ifu_req && !lsu_req;
                if (ifu_req || lsu_req) begin
                    grant = 1'b1;
                    if (ifu_req && lsu_req) begin
                        sel_lsu = !last_lsu_q;
                    end else begin
                        sel_lsu = lsu_req;
                    end
                    ifu_gnt = !sel_lsu;
                    lsu_gnt = sel_lsu;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_hit || (idx_q == SYSMAP_LAST_IDX)) begin
                    scan_done = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_RESP: begin
                rsp_vld = 1'b1;
                if (rsp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            last_lsu_q <= SRC_LSU;
            addr_q     <= '0;
            id_q       <= SRC_IFU;
            rsp_id     <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_attr   <= '0;
            rsp_region <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (grant) begin
                addr_q     <= sel_lsu ? lsu_addr : ifu_addr;
                id_q       <= sel_lsu;
                last_lsu_q <= sel_lsu;
            end
            if (scan_done) begin
                rsp_id     <= id_q;
                rsp_hit    <= scan_hit;
                rsp_attr   <= scan_hit ? rd_attr : SYSMAP_DFLT_ATTR;
                rsp_region <= idx_q;
            end
        end
    end

endmodule

// File: tb/tb_pa_sysmap_lookup_ctrl.sv
module tb_pa_sysmap_lookup_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, lsu_req, ifu_gnt, lsu_gnt;
    logic [19:0] ifu_addr, lsu_addr;
    logic        rsp_vld, rsp_rdy, rsp_id, rsp_hit;
    logic [4:0]  rsp_attr;
    logic [2:0]  rsp_region;
    logic        cfg_wr_vld, cfg_wr_rdy, cfg_wr_lock, cfg_wr_err;
    logic [2:0]  cfg_wr_idx;
    logic [19:0] cfg_wr_top;
    logic [4:0]  cfg_wr_attr;

    always #5 clk = ~clk;

    pa_sysmap_lookup_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .ifu_req        (ifu_req),
        .ifu_addr       (ifu_addr),
        .ifu_gnt        (ifu_gnt),
        .lsu_req        (lsu_req),
        .lsu_addr       (lsu_addr),
        .lsu_gnt        (lsu_gnt),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_id         (rsp_id),
        .rsp_hit        (rsp_hit),
        .rsp_attr       (rsp_attr),
        .rsp_region     (rsp_region),
        .cfg_wr_vld     (cfg_wr_vld),
        .cfg_wr_rdy     (cfg_wr_rdy),
        .cfg_wr_idx     (cfg_wr_idx),
        .cfg_wr_top     (cfg_wr_top),
        .cfg_wr_attr    (cfg_wr_attr),
        .cfg_wr_lock    (cfg_wr_lock),
        .cfg_wr_err     (cfg_wr_err)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [19:0] m_top  [8];
    logic [4:0]  m_attr [8];
    bit          m_lock [8];
    bit          m_busy;
    bit          m_last_lsu;
    int unsigned m_rsp_at;
    bit          m_err_exp;
    logic        m_id, m_hit, p_id, p_hit;
    logic [4:0]  m_a, p_a;
    logic [2:0]  m_r, p_r;

    function automatic void model_lookup(input logic [19:0] a, output logic hit,
                                         output logic [2:0] rg, output logic [4:0] at,
                                         output int unsigned lat);
        hit = 1'b0; rg = 3'd7; at = 5'b00011; lat = 9;
        for (int k = 0; k < 8; k++) begin
            if (a < m_top[k]) begin
                hit = 1'b1; rg = 3'(k); at = m_attr[k]; lat = 2 + k;
                break;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 8; k++) begin
            m_top[k] = '0; m_attr[k] = '0; m_lock[k] = 1'b0;
        end
        m_busy = 1'b0; m_last_lsu = 1'b1; m_rsp_at = 0; m_err_exp = 1'b0;
        m_id = 0; m_hit = 0; m_a = '0; m_r = '0;
        p_id = 0; p_hit = 0; p_a = '0; p_r = '0;
    endfunction

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        bit          exp_rdy, exp_vld, gi, gl, nxt_err;
        int unsigned lat;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                check("rst_ifu_gnt", 32'(ifu_gnt), 32'(0));
                check("rst_lsu_gnt", 32'(lsu_gnt), 32'(0));
                check("rst_rsp_vld", 32'(rsp_vld), 32'(0));
                check("rst_rsp_fields", {20'(0), rsp_id, rsp_hit, rsp_attr, rsp_region}, 32'(0));
                check("rst_cfg_wr_err", 32'(cfg_wr_err), 32'(0));
                check("rst_cfg_wr_rdy", 32'(cfg_wr_rdy), 32'(!ifu_req && !lsu_req));
            end else begin
                exp_rdy = !m_busy && !ifu_req && !lsu_req;
                gi = 1'b0; gl = 1'b0;
                if (!m_busy) begin
                    if (ifu_req && lsu_req) begin
                        if (m_last_lsu) gi = 1'b1; else gl = 1'b1;
                    end else if (ifu_req) gi = 1'b1;
                    else if (lsu_req) gl = 1'b1;
                end
                if (m_busy && cyc == m_rsp_at) begin
                    m_id = p_id; m_hit = p_hit; m_a = p_a; m_r = p_r;
                end
                exp_vld = m_busy && (cyc >= m_rsp_at);
                check("ifu_gnt", 32'(ifu_gnt), 32'(gi));
                check("lsu_gnt", 32'(lsu_gnt), 32'(gl));
                check("cfg_wr_rdy", 32'(cfg_wr_rdy), 32'(exp_rdy));
                check("rsp_vld", 32'(rsp_vld), 32'(exp_vld));
                check("rsp_fields", {20'(0), rsp_id, rsp_hit, rsp_attr, rsp_region},
                      {20'(0), m_id, m_hit, m_a, m_r});
                check("cfg_wr_err", 32'(cfg_wr_err), 32'(m_err_exp));

                nxt_err = 1'b0;
                if (exp_rdy && cfg_wr_vld) begin
`ifdef SYSMAP_CFG_LOCK_EN
                    if (m_lock[cfg_wr_idx]) begin
                        nxt_err = 1'b1;
                    end else begin
                        m_top[cfg_wr_idx]  = cfg_wr_top;
                        m_attr[cfg_wr_idx] = cfg_wr_attr;
                        if (cfg_wr_lock) m_lock[cfg_wr_idx] = 1'b1;
                    end
`else
                    m_top[cfg_wr_idx]  = cfg_wr_top;
                    m_attr[cfg_wr_idx] = cfg_wr_attr;
`endif
                end
                m_err_exp = nxt_err;
                if (gi || gl) begin
                    m_busy = 1'b1; m_last_lsu = gl; p_id = gl;
                    model_lookup(gl ? lsu_addr : ifu_addr, p_hit, p_r, p_a, lat);
                    m_rsp_at = cyc + lat;
                end else if (exp_vld && rsp_rdy) begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_lookup(input bit use_lsu, input logic [19:0] a, output int lat,
                             output logic id, output logic hit, output logic [4:0] at,
                             output logic [2:0] rg);
        bit got;
        int tg, tr;
        got = 0; tg = 0; tr = 0; id = 0; hit = 0; at = '0; rg = '0;
        if (use_lsu) begin lsu_addr = a; lsu_req = 1'b1; end
        else begin ifu_addr = a; ifu_req = 1'b1; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (use_lsu ? lsu_gnt : ifu_gnt) begin got = 1; tg = int'(cyc); end
        end
        check("lookup_gnt_seen", 32'(got), 32'(1));
        @(posedge clk); #1;
        ifu_req = 1'b0; lsu_req = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_vld) begin
                got = 1; tr = int'(cyc);
                id = rsp_id; hit = rsp_hit; at = rsp_attr; rg = rsp_region;
            end
        end
        check("lookup_rsp_seen", 32'(got), 32'(1));
        @(posedge clk); #1;
        lat = tr - tg;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [19:0] t, input logic [4:0] at,
                             input bit lk, output logic err);
        bit got;
        cfg_wr_idx = idx; cfg_wr_top = t; cfg_wr_attr = at; cfg_wr_lock = lk;
        cfg_wr_vld = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cfg_wr_rdy) got = 1;
        end
        check("cfg_accept_seen", 32'(got), 32'(1));
        @(posedge clk); #1;
        cfg_wr_vld = 1'b0; cfg_wr_lock = 1'b0;
        @(negedge clk);
        err = cfg_wr_err;
        @(posedge clk); #1;
    endtask

    function automatic logic [19:0] pick_addr();
        logic [19:0] base;
        if ($urandom_range(3) == 0) return 20'($urandom);
        base = m_top[$urandom_range(7)];
        return base + 20'($urandom_range(2)) - 20'd1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int          lat, tg, tr, rc;
        logic        id, hit, err;
        logic [4:0]  at;
        logic [2:0]  rg;
        bit          got, gi, gl, acc;
        logic        who [4];

        rst = 1'b1;
        ifu_req = 0; lsu_req = 0; ifu_addr = '0; lsu_addr = '0;
        rsp_rdy = 0; cfg_wr_vld = 0; cfg_wr_idx = '0; cfg_wr_top = '0;
        cfg_wr_attr = '0; cfg_wr_lock = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_cfg_wr_rdy", 32'(cfg_wr_rdy), 32'(1));
        @(posedge clk); #1;

        // Round robin with both requesters pending: IFU first after reset.
        rsp_rdy = 1'b1;
        ifu_addr = 20'h12345; lsu_addr = 20'h54321;
        ifu_req = 1'b1; lsu_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 0; who[g] = 1'bx;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (ifu_gnt || lsu_gnt) begin got = 1; who[g] = lsu_gnt; end
            end
            check("rr_gnt_seen", 32'(got), 32'(1));
            @(posedge clk); #1;
            if (g == 3) begin ifu_req = 0; lsu_req = 0; end
        end
        check("rr_order0", 32'(who[0]), 32'(0));
        check("rr_order1", 32'(who[1]), 32'(1));
        check("rr_order2", 32'(who[2]), 32'(0));
        check("rr_order3", 32'(who[3]), 32'(1));
        repeat (12) @(posedge clk);
        #1;

        // Directed region table.
        cfg_write(3'd0, 20'h00100, 5'h11, 0, err);
        cfg_write(3'd1, 20'h00200, 5'h12, 0, err);
        cfg_write(3'd2, 20'h80000, 5'h14, 0, err);

        do_lookup(0, 20'h00150, lat, id, hit, at, rg);
        check("ifu_150_lat", 32'(lat), 32'(3));
        check("ifu_150_res", {26'(0), id, hit, rg}, {26'(0), 1'b0, 1'b1, 3'd1});
        check("ifu_150_attr", 32'(at), 32'h12);
        do_lookup(1, 20'h00200, lat, id, hit, at, rg);
        check("lsu_200_lat", 32'(lat), 32'(4));
        check("lsu_200_res", {26'(0), id, hit, rg}, {26'(0), 1'b1, 1'b1, 3'd2});
        do_lookup(1, 20'h90000, lat, id, hit, at, rg);
        check("lsu_miss_lat", 32'(lat), 32'(9));
        check("lsu_miss_res", {21'(0), hit, at, rg}, {21'(0), 1'b0, 5'b00011, 3'd7});
        do_lookup(0, 20'h000FF, lat, id, hit, at, rg);
        check("ifu_0ff_region", {28'(0), hit, rg}, {28'(0), 1'b1, 3'd0});
        check("ifu_0ff_lat", 32'(lat), 32'(2));
        do_lookup(0, 20'h00100, lat, id, hit, at, rg);
        check("ifu_top0_boundary", 32'(rg), 32'(1));

        // Back-pressure: response held while rsp_rdy is low, LSU waits.
        rsp_rdy = 1'b0;
        ifu_addr = 20'h00150; ifu_req = 1'b1;
        got = 0; tg = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ifu_gnt) begin got = 1; tg = int'(cyc); end
        end
        check("bp_gnt_seen", 32'(got), 32'(1));
        @(posedge clk); #1;
        ifu_req = 1'b0; lsu_addr = 20'h00050; lsu_req = 1'b1;
        got = 0; tr = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_vld) begin got = 1; tr = int'(cyc); end
        end
        check("bp_rsp_seen", 32'(got), 32'(1));
        check("bp_lat", 32'(tr - tg), 32'(3));
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_vld", 32'(rsp_vld), 32'(1));
            check("bp_hold_fields", {20'(0), rsp_id, rsp_hit, rsp_attr, rsp_region},
                  {20'(0), 1'b0, 1'b1, 5'h12, 3'd1});
            check("bp_hold_no_gnt", 32'(lsu_gnt), 32'(0));
        end
        @(posedge clk); #1;
        rsp_rdy = 1'b1;
        @(negedge clk);
        rc = int'(cyc);
        check("bp_release_no_gnt", 32'(lsu_gnt), 32'(0));
        got = 0; tg = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (lsu_gnt) begin got = 1; tg = int'(cyc); end
        end
        check("bp_next_gnt_delay", 32'(tg - rc), 32'(1));
        @(posedge clk); #1;
        lsu_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Reset while scanning region 4: lookup is abandoned, table cleared.
        cfg_write(3'd4, 20'hF0000, 5'h1F, 0, err);
        ifu_addr = 20'hA0000; ifu_req = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ifu_gnt) got = 1;
        end
        check("rstscan_gnt_seen", 32'(got), 32'(1));
        @(posedge clk); #1;
        ifu_req = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("rstscan_no_rsp", 32'(rsp_vld), 32'(0));
        end
        @(posedge clk); #1;
        do_lookup(0, 20'h00000, lat, id, hit, at, rg);
        check("rstscan_tops_zero_hit", 32'(hit), 32'(0));
        check("rstscan_tops_zero_lat", 32'(lat), 32'(9));
        do_lookup(1, 20'hFFFFF, lat, id, hit, at, rg);
        check("rstscan_tops_zero_attr", 32'(at), 32'(5'b00011));

        // Region lock behaviour.
        cfg_write(3'd3, 20'h00300, 5'h0A, 1, err);
        check("lock_first_err", 32'(err), 32'(0));
        cfg_write(3'd3, 20'h00400, 5'h0B, 0, err);
        do_lookup(0, 20'h00350, lat, id, hit, at, rg);
`ifdef SYSMAP_CFG_LOCK_EN
        check("lock_rewrite_err", 32'(err), 32'(1));
        check("lock_rewrite_blocked", 32'(hit), 32'(0));
`else
        check("lock_rewrite_err", 32'(err), 32'(0));
        check("lock_rewrite_taken", {27'(0), hit, at[3:0]}, {27'(0), 1'b1, 4'hB});
        check("lock_rewrite_lat", 32'(lat), 32'(5));
`endif

        // Randomised traffic; the compare process does the checking.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            gi = ifu_gnt; gl = lsu_gnt; acc = cfg_wr_vld && cfg_wr_rdy;
            @(posedge clk); #1;
            if (gi) ifu_req = 1'b0;
            if (gl) lsu_req = 1'b0;
            if (acc) begin cfg_wr_vld = 1'b0; cfg_wr_lock = 1'b0; end
            if (c < 560) begin
                if (!ifu_req && !gi && $urandom_range(3) == 0) begin
                    ifu_addr = pick_addr(); ifu_req = 1'b1;
                end
                if (!lsu_req && !gl && $urandom_range(3) == 0) begin
                    lsu_addr = pick_addr(); lsu_req = 1'b1;
                end
                if (!cfg_wr_vld && !acc && $urandom_range(5) == 0) begin
                    cfg_wr_idx  = 3'($urandom_range(7));
                    cfg_wr_top  = ($urandom_range(1) == 0) ? 20'($urandom) : 20'($urandom_range(16'hFFFF));
                    cfg_wr_attr = 5'($urandom);
                    cfg_wr_lock = ($urandom_range(7) == 0);
                    cfg_wr_vld  = 1'b1;
                end
            end
            rsp_rdy = ($urandom_range(2) != 0);
        end
        rsp_rdy = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            gi = ifu_gnt; gl = lsu_gnt;
            if (cfg_wr_rdy && !cfg_wr_vld) got = 1;
            @(posedge clk); #1;
            if (gi) ifu_req = 1'b0;
            if (gl) lsu_req = 1'b0;
            if (cfg_wr_vld && !ifu_req && !lsu_req) cfg_wr_vld = 1'b0;
        end
        check("random_drain_idle", 32'(got), 32'(1));
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pa_sysmap_lookup_ctrl.md
PA_SYSMAP_LOOKUP_CTRL -- requirements
Module: pa_sysmap_lookup_ctrl

Interface
REQ-001 SHALL have port forever_cpuclk, input, 1: sole clock, all flops rising-edge.
REQ-002 SHALL have port cpurst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have ports ifu_req / lsu_req, input, 1 each: lookup request, held high until the matching grant.
REQ-004 SHALL have ports ifu_addr / lsu_addr, input, 20 each: address[31:12], stable while the request is high.
REQ-005 SHALL have ports ifu_gnt / lsu_gnt, output, 1 each: one-cycle grant pulse; the address is captured on this cycle.
REQ-006 SHALL have ports rsp_vld output 1, rsp_rdy input 1, rsp_id output 1 (0=IFU, 1=LSU), rsp_hit output 1, rsp_attr output 5, rsp_region output 3.
REQ-007 SHALL have ports cfg_wr_vld input 1, cfg_wr_rdy output 1, cfg_wr_idx input 3, cfg_wr_top input 20, cfg_wr_attr input 5.
REQ-008 SHALL have ports cfg_wr_lock input 1 and cfg_wr_err output 1, both functional only under SYSMAP_CFG_LOCK_EN.

Function
REQ-009 SHALL hold 8 regions, each a 20-bit top and 5-bit attr; region k bottom = top[k-1]; region 0 bottom = 0.
REQ-010 SHALL treat region k as hit when addr >= bottom_k and addr < top_k (unsigned); addr == top_k is not a hit in region k.
REQ-011 SHALL implement FSM IDLE -> SCAN -> RESP -> IDLE.
REQ-012 IDLE: a pending request SHALL be granted in the same cycle, idx cleared to 0, state set to SCAN.
REQ-013 IDLE arbitration: a single request is granted directly; with both requests pending, round-robin against a 1-bit last-grant flag (reset value selects IFU first).
REQ-014 SCAN: compare one region per cycle in ascending idx order; on the first addr < top[idx], latch hit=1, attr and region=idx, then go to RESP.
REQ-015 SCAN with idx==7 and no hit SHALL latch hit=0, attr=SYSMAP_DFLT_ATTR, region=7, then go to RESP.
REQ-016 Latency: grant at cycle T; hit in region k gives rsp_vld at T+2+k; a miss gives rsp_vld at T+9.
REQ-017 RESP: rsp_vld=1 with all rsp_* fields stable until rsp_rdy=1; that cycle SHALL return to IDLE, and no grant SHALL occur in that same cycle.
REQ-018 cfg_wr_rdy SHALL equal (state==IDLE and neither request pending); a write takes effect when cfg_wr_vld and cfg_wr_rdy are both high, visible to the next grant.
REQ-019 Requests have priority over config writes; cfg_wr_vld held by the master SHALL wait while requests keep arriving (no starvation guarantee required).
REQ-020 Tops are not required to be monotonic; the first-match-by-index rule SHALL apply regardless.

Reset
REQ-021 On cpurst: state=IDLE, idx=0, last-grant=LSU, all tops=0, all attr=0, lock bits=0.
REQ-022 Reset outputs: gnts=0, rsp_vld=0, rsp_id=0, rsp_hit=0, rsp_attr=0, rsp_region=0, cfg_wr_err=0, cfg_wr_rdy follows REQ-018 (1 with no requests).
REQ-023 Reset asserted mid-SCAN or mid-RESP SHALL abandon the lookup with no response issued.

Configuration
REQ-024 Macro SYSMAP_CFG_LOCK_EN defined: each region SHALL have a sticky lock bit, set by an accepted write with cfg_wr_lock=1; a later write to a locked region is ignored and cfg_wr_err pulses high for 1 cycle.
REQ-025 Macro SYSMAP_CFG_LOCK_EN undefined: no lock bits, every accepted write updates the region, cfg_wr_err tied 0, cfg_wr_lock ignored.

Structure
REQ-026 Package pa_sysmap_pkg SHALL hold SYSMAP_REGION_NUM=8, SYSMAP_ADDR_W=20, SYSMAP_ATTR_W=5, SYSMAP_DFLT_ATTR=5'b00011 and the FSM state encoding.
REQ-027 The region register file, including lock bits, SHALL be sub-module pa_sysmap_cfg_regs with a write port and one indexed read port; arbitration and FSM stay in the top level.

Verification
REQ-028 Write top[0..2]=0x00100/0x00200/0x80000; IFU addr=0x00150 -> rsp_hit=1, rsp_region=1, rsp_vld at T+3.
REQ-029 LSU addr=0x00200 with the REQ-028 setup -> region 2 (boundary), rsp_id=1; addr=0x90000 -> rsp_hit=0, attr=5'b00011, rsp_vld at T+9.
REQ-030 IFU and LSU requesting together for 4 lookups -> grants alternate IFU, LSU, IFU, LSU.
REQ-031 rsp_rdy held low 5 cycles -> rsp_vld and fields remain stable; no new grant until the cycle after rsp_rdy.
REQ-032 cpurst pulsed during SCAN of region 4 -> no rsp_vld; state IDLE; all tops read back 0.
REQ-033 With SYSMAP_CFG_LOCK_EN: write region 3 with lock=1, then rewrite it -> cfg_wr_err=1 for 1 cycle, top[3] unchanged; without the macro the rewrite succeeds.
